// File: rtl/ps2_key_mapper.sv
// ps2_key_mapper: PS/2 Set-2 scancode parser feeding held-key levels to input_manager.
// Handles make, F0 break, E0 extended and E1 Pause sequences, with an inter-byte
// timeout for stuck prefixes. A receiver error or a timeout drops any pending prefix.
// Optional build macro: WASD_KEYS_EN adds W/A/S/D key flops OR'd into the direction outputs.
//
// state   | code | meaning
// IDLE    | 0    | waiting for a new sequence
// BRK     | 1    | F0 seen, next code releases a key
// EXT     | 2    | E0 seen, next code is an extended make
// EXT_BRK | 3    | E0 F0 seen, next code is an extended break
// SKIP    | 4    | discarding the remainder of a Pause sequence
module ps2_key_mapper #(
  parameter int PREFIX_TIMEOUT = 200000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  input  logic       ps2_err,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate_cw,
  output logic       raw_rotate_ccw,
  output logic       raw_drop,
  output logic       raw_hold,
  output logic [2:0] parse_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BRK     = 3'd1,
    EXT     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam int SW = $clog2(PAUSE_SKIP + 1);

  // Key flop indices; the WASD flops only exist when the feature is built in.
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_DOWN  = 2;
  localparam int K_UP    = 3;
  localparam int K_X     = 4;
  localparam int K_Z     = 5;
  localparam int K_SPACE = 6;
  localparam int K_C     = 7;
  localparam int K_LSH   = 8;
`ifdef WASD_KEYS_EN
  localparam int K_A     = 9;
  localparam int K_D     = 10;
  localparam int K_S     = 11;
  localparam int K_W     = 12;
  localparam int NK      = 13;
`else
  localparam int NK      = 9;
`endif

  state_t        state_q, state_d;
  logic [NK-1:0] keys_q, keys_d;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [NK-1:0] hit_mask;
  logic [TW-1:0] tmo_inc;
  logic          is_ext;
  logic          is_brk;

  // Decode the current byte into a one-hot key mask for the active lookup table.
  always_comb begin
    hit_mask = '0;
    is_ext   = (state_q == EXT) || (state_q == EXT_BRK);
    is_brk   = (state_q == BRK) || (state_q == EXT_BRK);
    if (is_ext) begin
      case (ps2_data)
        8'h6B:   hit_mask[K_LEFT]  = 1'b1;
        8'h74:   hit_mask[K_RIGHT] = 1'b1;
        8'h72:   hit_mask[K_DOWN]  = 1'b1;
        8'h75:   hit_mask[K_UP]    = 1'b1;
        default: hit_mask = '0;
      endcase
    end else if (state_q == IDLE || state_q == BRK) begin
      case (ps2_data)
        8'h22:   hit_mask[K_X]     = 1'b1;
        8'h1A:   hit_mask[K_Z]     = 1'b1;
        8'h29:   hit_mask[K_SPACE] = 1'b1;
        8'h21:   hit_mask[K_C]     = 1'b1;
        8'h12:   hit_mask[K_LSH]   = 1'b1;
`ifdef WASD_KEYS_EN
        8'h1C:   hit_mask[K_A]     = 1'b1;
        8'h23:   hit_mask[K_D]     = 1'b1;
        8'h1B:   hit_mask[K_S]     = 1'b1;
        8'h1D:   hit_mask[K_W]     = 1'b1;
`endif
        default: hit_mask = '0;
      endcase
    end
  end

  // Next-state logic: parser FSM, Pause skip counter, prefix timeout and key flops.
  always_comb begin
    state_d    = state_q;
    keys_d     = keys_q;
    skip_cnt_d = skip_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_inc    = (tmo_cnt_q == {TW{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    if (ps2_err) begin
      // Error beats a coincident byte: drop it and any pending prefix.
      state_d    = IDLE;
      skip_cnt_d = '0;
      tmo_cnt_d  = '0;
    end else if (ps2_valid) begin
      tmo_cnt_d = '0;
      if (state_q == SKIP) begin
        skip_cnt_d = skip_cnt_q - 1'b1;
        if (skip_cnt_q <= SW'(1)) begin
          state_d    = IDLE;
          skip_cnt_d = '0;
        end
      end else begin
        case (ps2_data)
          8'hF0: state_d = is_ext ? EXT_BRK : BRK;
          8'hE0: state_d = EXT;
          8'hE1: begin
            state_d    = SKIP;
            skip_cnt_d = SW'(PAUSE_SKIP);
          end
          default: begin
            state_d = IDLE;
            if (state_q == IDLE &&
                (ps2_data == 8'hAA || ps2_data == 8'h00 || ps2_data == 8'hFF)) begin
              // BAT completion or receiver overrun: key state can no longer be trusted.
              keys_d = '0;
            end else if (is_brk) begin
              keys_d = keys_q & ~hit_mask;
            end else begin
              keys_d = keys_q | hit_mask;
            end
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      tmo_cnt_d = tmo_inc;
      if (tmo_inc >= TW'(PREFIX_TIMEOUT)) begin
        state_d    = IDLE;
        skip_cnt_d = '0;
        tmo_cnt_d  = '0;
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      keys_q     <= '0;
      skip_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      keys_q     <= keys_d;
      skip_cnt_q <= skip_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  logic wasd_left, wasd_right, wasd_down, wasd_up;
`ifdef WASD_KEYS_EN
  assign wasd_left  = keys_q[K_A];
  assign wasd_right = keys_q[K_D];
  assign wasd_down  = keys_q[K_S];
  assign wasd_up    = keys_q[K_W];
`else
  assign wasd_left  = 1'b0;
  assign wasd_right = 1'b0;
  assign wasd_down  = 1'b0;
  assign wasd_up    = 1'b0;
`endif

  assign raw_left       = keys_q[K_LEFT]  | wasd_left;
  assign raw_right      = keys_q[K_RIGHT] | wasd_right;
  assign raw_down       = keys_q[K_DOWN]  | wasd_down;
  assign raw_rotate_cw  = keys_q[K_UP] | keys_q[K_X] | wasd_up;
  assign raw_rotate_ccw = keys_q[K_Z];
  assign raw_drop       = keys_q[K_SPACE];
  assign raw_hold       = keys_q[K_C] | keys_q[K_LSH];
  assign parse_state    = state_q;

endmodule
